mac_operand_sequencer: RTL and testbench

Initiator-side driver for the `top_mac` multiply-accumulate unit. It holds a small programmable operand-pair buffer. On `start` it clears the MAC, streams `len` operand pairs into it one per cycle, and waits out the MAC pipeline latency. It then captures the accumulated sum as a held result with a one-cycle `done` pulse. It replaces bench-driven stimulus when the MAC is used inside a larger datapath.

---
 rtl/mac_operand_sequencer.sv | 150 +++++++++++++++
 tb/tb_mac_operand_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mac_operand_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | mac_operand_sequencer: streams buffered operand pairs into top_mac     |
// | and captures the accumulated sum.               Revision: 1.0          |
// +------------------------------------------------------------------------+
module mac_operand_sequencer #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int DW      = 8,
  parameter int ACC_W   = 22,
  parameter int MAC_LAT = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [DW-1:0]    wr_a_i,
  input  logic [DW-1:0]    wr_b_i,
  input  logic             start_i,
  input  logic [AW:0]      len_i,
  output logic             mac_rst_o,
  output logic [DW-1:0]    mac_a_o,
  output logic [DW-1:0]    mac_b_o,
  input  logic [ACC_W-1:0] mac_y_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [ACC_W-1:0] result_o
);

  localparam int LW  = AW + 1;
  localparam int DCW = $clog2(MAC_LAT + 1);
  localparam logic [LW-1:0] LEN_MAX = LW'(DEPTH);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLEAR   = 3'd1;
  localparam logic [2:0] S_STREAM  = 3'd2;
  localparam logic [2:0] S_DRAIN   = 3'd3;
  localparam logic [2:0] S_CAPTURE = 3'd4;

  logic [DW-1:0] mem_a [DEPTH];
  logic [DW-1:0] mem_b [DEPTH];

  logic [2:0]       state_q,   state_d;
  logic [LW-1:0]    idx_q,     idx_d;
  logic [LW-1:0]    len_q,     len_d;
  logic [DCW-1:0]   drain_q,   drain_d;
  logic [DW-1:0]    mac_a_q,   mac_a_d;
  logic [DW-1:0]    mac_b_q,   mac_b_d;
  logic             mac_rst_q, mac_rst_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;
  logic [ACC_W-1:0] result_q,  result_d;
  logic [DW-1:0]    rd_a, rd_b;

  // Writes are frozen out for the whole run so the streamed data cannot change.
  always_ff @(posedge clk_i) begin
    if (wr_en_i && !busy_q) begin
      mem_a[wr_addr_i] <= wr_a_i;
      mem_b[wr_addr_i] <= wr_b_i;
    end
  end

  assign rd_a = mem_a[idx_q[AW-1:0]];
  assign rd_b = mem_b[idx_q[AW-1:0]];

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    drain_d   = drain_q;
    mac_a_d   = '0;
    mac_b_d   = '0;
    mac_rst_d = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    result_d  = result_q;
    case (state_q)
      // The done cycle behaves as IDLE so back-to-back starts are accepted.
      S_IDLE, S_CAPTURE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        if (start_i && (len_i != '0)) begin
          state_d   = S_CLEAR;
          len_d     = (len_i > LEN_MAX) ? LEN_MAX : len_i;
          idx_d     = '0;
          mac_rst_d = 1'b1;
          busy_d    = 1'b1;
        end
      end
      S_CLEAR, S_STREAM: begin
        if (idx_q == len_q) begin
          state_d = S_DRAIN;
          drain_d = DCW'(MAC_LAT);
        end else begin
          state_d = S_STREAM;
          mac_a_d = rd_a;
          mac_b_d = rd_b;
          idx_d   = idx_q + LW'(1);
        end
      end
      S_DRAIN: begin
        if (drain_q == DCW'(1)) begin
          state_d  = S_CAPTURE;
          drain_d  = '0;
          result_d = mac_y_i;
          done_d   = 1'b1;
          busy_d   = 1'b0;
        end else begin
          drain_d = drain_q - DCW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      len_q     <= '0;
      drain_q   <= '0;
      mac_a_q   <= '0;
      mac_b_q   <= '0;
      mac_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      drain_q   <= drain_d;
      mac_a_q   <= mac_a_d;
      mac_b_q   <= mac_b_d;
      mac_rst_q <= mac_rst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
    end
  end

  assign mac_rst_o = mac_rst_q;
  assign mac_a_o   = mac_a_q;
  assign mac_b_o   = mac_b_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign result_o  = result_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_operand_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_mac_operand_sequencer: directed bench with a behavioural MAC.       |
// |                                                 Revision: 1.0          |
// +------------------------------------------------------------------------+
module tb_mac_operand_sequencer;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int ACC_W = 22;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b0;
  logic             wr_en_i = 1'b0;
  logic [AW-1:0]    wr_addr_i = '0;
  logic [DW-1:0]    wr_a_i = '0;
  logic [DW-1:0]    wr_b_i = '0;
  logic             start_i = 1'b0;
  logic [AW:0]      len_i = '0;
  logic             mac_rst_o;
  logic [DW-1:0]    mac_a_o;
  logic [DW-1:0]    mac_b_o;
  logic [ACC_W-1:0] mac_y;
  logic             busy_o;
  logic             done_o;
  logic [ACC_W-1:0] result_o;

  int errors = 0;
  int checks = 0;

  mac_operand_sequencer #(
    .DEPTH(DEPTH), .AW(AW), .DW(DW), .ACC_W(ACC_W), .MAC_LAT(1)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
    .wr_a_i(wr_a_i), .wr_b_i(wr_b_i), .start_i(start_i), .len_i(len_i),
    .mac_rst_o(mac_rst_o), .mac_a_o(mac_a_o), .mac_b_o(mac_b_o),
    .mac_y_i(mac_y), .busy_o(busy_o), .done_o(done_o), .result_o(result_o)
  );

  always #5 clk_i = ~clk_i;

  // Single-stage accumulator standing in for top_mac.
  always @(posedge clk_i) begin
    if (mac_rst_o) mac_y <= '0;
    else           mac_y <= mac_y + ACC_W'(mac_a_o) * ACC_W'(mac_b_o);
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input int addr, input int a, input int b);
    wr_en_i   = 1'b1;
    wr_addr_i = AW'(addr);
    wr_a_i    = DW'(a);
    wr_b_i    = DW'(b);
    step();
    wr_en_i   = 1'b0;
  endtask

  // Pulses start, waits (bounded) for done, checks latency, busy length, result.
  task automatic run(input string tag, input int len, input int exp_res, input int exp_edges);
    int edges;
    int busy_cnt;
    start_i = 1'b1;
    len_i   = (AW+1)'(len);
    step();
    start_i  = 1'b0;
    edges    = 1;
    busy_cnt = 0;
    while (!done_o && edges < 100) begin
      if (busy_o) busy_cnt++;
      step();
      edges++;
    end
    chk({tag, "_done_seen"}, 32'(done_o), 32'd1);
    chk({tag, "_latency"}, 32'(edges), 32'(exp_edges));
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_edges - 1));
    chk({tag, "_result"}, 32'(result_o), 32'(exp_res));
    step();
  endtask

  int basic_a [5] = '{1, 2, 3, 4, 5};
  int basic_b [5] = '{9, 8, 7, 6, 5};

  initial begin
    int busy_seen;

    // Reset state
    step(); step();
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_result", 32'(result_o), 32'd0);
    chk("rst_mac_rst", 32'(mac_rst_o), 32'd1);
    chk("rst_mac_a", 32'(mac_a_o), 32'd0);
    chk("rst_mac_b", 32'(mac_b_o), 32'd0);
    rst_i = 1'b1;
    step();
    chk("rst_release_mac_rst", 32'(mac_rst_o), 32'd0);

    for (int i = 0; i < 5; i++) wr(i, basic_a[i], basic_b[i]);

    // Basic run, cycle by cycle
    start_i = 1'b1;
    len_i   = 5'd5;
    step();
    start_i = 1'b0;
    chk("basic_clear_mac_rst", 32'(mac_rst_o), 32'd1);
    chk("basic_clear_busy", 32'(busy_o), 32'd1);
    chk("basic_clear_mac_a", 32'(mac_a_o), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("basic_stream_mac_rst", 32'(mac_rst_o), 32'd0);
      chk("basic_stream_mac_a", 32'(mac_a_o), 32'(basic_a[i]));
      chk("basic_stream_mac_b", 32'(mac_b_o), 32'(basic_b[i]));
    end
    step();
    chk("basic_drain_mac_a", 32'(mac_a_o), 32'd0);
    chk("basic_drain_busy", 32'(busy_o), 32'd1);
    chk("basic_drain_done", 32'(done_o), 32'd0);
    step();
    chk("basic_done", 32'(done_o), 32'd1);
    chk("basic_busy_low", 32'(busy_o), 32'd0);
    chk("basic_result", 32'(result_o), 32'd95);
    step();
    chk("basic_done_pulse", 32'(done_o), 32'd0);
    chk("basic_result_held", 32'(result_o), 32'd95);

    run("basic_run", 5, 95, 8);

    // len=0 is ignored
    start_i = 1'b1;
    len_i   = 5'd0;
    step(); step();
    start_i = 1'b0;
    chk("len0_busy", 32'(busy_o), 32'd0);
    chk("len0_done", 32'(done_o), 32'd0);
    step();
    chk("len0_busy_later", 32'(busy_o), 32'd0);

    // start and write while busy are dropped
    start_i = 1'b1;
    len_i   = 5'd5;
    step();
    start_i = 1'b0;
    step(); step();
    start_i   = 1'b1;
    wr_en_i   = 1'b1;
    wr_addr_i = '0;
    wr_a_i    = 8'd7;
    wr_b_i    = 8'd7;
    step();
    start_i = 1'b0;
    wr_en_i = 1'b0;
    for (int i = 0; i < 20 && !done_o; i++) step();
    chk("busyreq_done", 32'(done_o), 32'd1);
    chk("busyreq_result", 32'(result_o), 32'd95);
    busy_seen = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (busy_o) busy_seen++;
    end
    chk("busyreq_no_second_run", 32'(busy_seen), 32'd0);
    run("busyreq_entry0_kept", 5, 95, 8);

    // Reset mid-run
    start_i = 1'b1;
    len_i   = 5'd5;
    step();
    start_i = 1'b0;
    step(); step();
    rst_i = 1'b0;
    step();
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_done", 32'(done_o), 32'd0);
    chk("midrst_result", 32'(result_o), 32'd0);
    chk("midrst_mac_rst", 32'(mac_rst_o), 32'd1);
    chk("midrst_mac_a", 32'(mac_a_o), 32'd0);
    rst_i = 1'b1;
    step();
    chk("midrst_release_mac_rst", 32'(mac_rst_o), 32'd0);
    run("midrst_rerun", 5, 95, 8);

    // Back-to-back: start during the done cycle, len=2 gives 1*9+2*8=25
    start_i = 1'b1;
    len_i   = 5'd5;
    step();
    start_i = 1'b0;
    for (int i = 0; i < 20 && !done_o; i++) step();
    chk("b2b_first_done", 32'(done_o), 32'd1);
    chk("b2b_first_result", 32'(result_o), 32'd95);
    run("b2b_second", 2, 25, 5);

    // Full scale and clamped length
    for (int i = 0; i < DEPTH; i++) wr(i, 255, 255);
    run("full_scale", 16, 1040400, 19);
    run("len20_clamp", 20, 1040400, 19);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Back-to-back detail: CLEAR follows the done cycle and result is held.
  initial begin
    forever begin
      @(posedge clk_i);
      #2;
      if (done_o && start_i && len_i == 5'd2) begin
        step();
        chk("b2b_clear_mac_rst", 32'(mac_rst_o), 32'd1);
        chk("b2b_clear_busy", 32'(busy_o), 32'd1);
        chk("b2b_result_held", 32'(result_o), 32'd95);
      end
    end
  end

endmodule
`default_nettype wire
